lcd_pixel_feeder: RTL and testbench

LCD_PIXEL_FEEDER -- requirements
Module: lcd_pixel_feeder

---
 rtl/lcd_pixel_feeder.sv | 168 ++++++++++++++++
 tb/tb_lcd_pixel_feeder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_feeder.sv
// lcd_pixel_feeder
//
// Streams 16-bit pixel words from an upstream frame FIFO to an RGB panel
// path. It generates the panel raster timing and issues one FIFO read per
// active pixel slot.
//
// Latency model: the horizontal and vertical counters define slot t. The
// read request for slot t is combinational in cycle t. Every panel output
// (en, den, hsync_n, vsync_n, frame_start, out_source_data) appears in cycle
// t+1, so the panel sees one consistent one-cycle latency.
//
// Ports:
//   clk_9            in   pixel clock (only clock)
//   reset_n          in   synchronous active-low reset
//   fifo_q[15:0]     in   FIFO word, valid the cycle after fifo_rdreq
//   fifo_empty       in   FIFO empty flag
//   fifo_rdreq       out  FIFO read request (one word per cycle asserted)
//   out_source_data  out  pixel word to colour converter
//   en               out  pixel-valid strobe
//   hsync_n/vsync_n  out  panel syncs, active low
//   den              out  panel data enable, identical to en
//   frame_start      out  one-cycle pulse marking raster position (0,0)
//   underflow        out  sticky underflow flag
//
// Build option FEEDER_UNDERFLOW_FILL_EN:
//   defined   - a starved slot emits 16'h00FF; underflow is set and stays
//               set until reset or the next frame_start
//   undefined - a starved slot repeats the previous word; underflow is 0

module lcd_pixel_feeder #(
    parameter int unsigned H_SYNC   = 41,
    parameter int unsigned H_BP     = 2,
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned H_FP     = 2,
    parameter int unsigned V_SYNC   = 10,
    parameter int unsigned V_BP     = 2,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned V_FP     = 2
) (
    input  logic        clk_9,
    input  logic        reset_n,
    input  logic [15:0] fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    output logic [15:0] out_source_data,
    output logic        en,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        den,
    output logic        frame_start,
    output logic        underflow
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    // One extra count of headroom keeps the window end representable.
    localparam int unsigned HW = $clog2(H_TOTAL + 1);
    localparam int unsigned VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_act, v_act, act_slot, origin;
    logic          rd_q;
    logic          en_q, hsync_q, vsync_q, fs_q;
    logic [15:0]   data_q, data_d;

    // Raster counters
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    assign h_act    = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END);
    assign v_act    = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    assign act_slot = h_act && v_act;
    assign origin   = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Gated by reset_n so that no word is consumed in a reset cycle,
    // even when the counters still point into the active window.
    assign fifo_rdreq = reset_n && act_slot && !fifo_empty;

    always_ff @(posedge clk_9) begin
        if (!reset_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            rd_q    <= 1'b0;
            en_q    <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            fs_q    <= 1'b0;
            data_q  <= 16'h0000;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            rd_q    <= fifo_rdreq;
            en_q    <= act_slot;
            hsync_q <= !(h_cnt_q < H_SYNC_END);
            vsync_q <= !(v_cnt_q < V_SYNC_END);
            fs_q    <= origin;
            data_q  <= data_d;
        end
    end

`ifdef FEEDER_UNDERFLOW_FILL_EN
    logic fill_q;   // previous slot was active but starved
    logic uf_q;

    always_ff @(posedge clk_9) begin
        if (!reset_n) begin
            fill_q <= 1'b0;
            uf_q   <= 1'b0;
        end else begin
            fill_q <= act_slot && fifo_empty;
            // Clearing at the frame origin makes the flag drop in the same
            // cycle that frame_start is presented.
            if (origin) begin
                uf_q <= 1'b0;
            end else if (act_slot && fifo_empty) begin
                uf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        data_d = data_q;
        if (rd_q) begin
            data_d = fifo_q;
        end else if (fill_q) begin
            data_d = 16'h00FF;
        end
    end

    assign underflow = uf_q;
`else
    // A starved slot simply keeps presenting the last word.
    always_comb begin
        data_d = data_q;
        if (rd_q) begin
            data_d = fifo_q;
        end
    end

    assign underflow = 1'b0;
`endif

    // fifo_q is only valid in the cycle after the read, so the word is
    // forwarded combinationally and captured for the hold case.
    assign out_source_data = data_d;
    assign en              = en_q;
    assign den             = en_q;
    assign hsync_n         = hsync_q;
    assign vsync_n         = vsync_q;
    assign frame_start     = fs_q;

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Self-checking bench for lcd_pixel_feeder. The raster is shrunk so that
// several complete frames fit in a short run. The expected behaviour is
// derived from a linear slot position p within the frame, where
// h = p % HT and v = p / HT.
module tb_lcd_pixel_feeder;

    localparam int HS = 4;
    localparam int HB = 2;
    localparam int HA = 10;
    localparam int HF = 3;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VA = 4;
    localparam int VF = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;

    logic        clk_9;
    logic        reset_n;
    logic [15:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic [15:0] out_source_data;
    logic        en, hsync_n, vsync_n, den, frame_start, underflow;

    lcd_pixel_feeder #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF)
    ) dut (
        .clk_9          (clk_9),
        .reset_n        (reset_n),
        .fifo_q         (fifo_q),
        .fifo_empty     (fifo_empty),
        .fifo_rdreq     (fifo_rdreq),
        .out_source_data(out_source_data),
        .en             (en),
        .hsync_n        (hsync_n),
        .vsync_n        (vsync_n),
        .den            (den),
        .frame_start    (frame_start),
        .underflow      (underflow)
    );

    initial clk_9 = 1'b0;
    always #5 clk_9 = ~clk_9;

    // FIFO contents: an incrementing run first, then random words
    logic [15:0] mem [0:4095];
    int dut_idx, exp_idx;

    // Reference model state
    int          p, cyc, last_fs, en_cnt;
    logic        e_en, e_hs, e_vs, e_fs, e_uf;
    logic [15:0] e_data;
    int          total, bad;

    function automatic bit active(input int pp);
        int h, v;
        h = pp % HT;
        v = pp / HT;
        return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    endfunction

    function automatic int pos(input int v, input int h);
        return v * HT + h;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check at negedge, advance the model.
    task automatic tick(input logic rstn, input logic empty);
        bit   act, exp_rd, fs_now;
        logic rd_seen;
        int   h, v;
        reset_n    = rstn;
        fifo_empty = empty;
        @(negedge clk_9);
        act    = active(p);
        exp_rd = rstn && act && !empty;
        check("fifo_rdreq", 32'(fifo_rdreq), 32'(exp_rd));
        check("en", 32'(en), 32'(e_en));
        check("den", 32'(den), 32'(e_en));
        check("hsync_n", 32'(hsync_n), 32'(e_hs));
        check("vsync_n", 32'(vsync_n), 32'(e_vs));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("out_source_data", 32'(out_source_data), 32'(e_data));
        check("underflow", 32'(underflow), 32'(e_uf));
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) begin
                check("frame_period", 32'(cyc - last_fs), 32'(FT));
                check("en_per_frame", 32'(en_cnt), 32'(HA * VA));
            end
            last_fs = cyc;
            en_cnt  = 0;
        end
        if (en === 1'b1) en_cnt++;
        rd_seen = fifo_rdreq;
        @(posedge clk_9);
        #1;
        cyc++;
        // Normal-mode FIFO: the popped word appears the cycle after the request
        if (rd_seen === 1'b1) begin
            fifo_q = mem[dut_idx];
            dut_idx++;
        end
        if (!rstn) begin
            p       = 0;
            e_en    = 1'b0;
            e_hs    = 1'b1;
            e_vs    = 1'b1;
            e_fs    = 1'b0;
            e_data  = 16'h0000;
            e_uf    = 1'b0;
            last_fs = -1;
            en_cnt  = 0;
        end else begin
            h      = p % HT;
            v      = p / HT;
            fs_now = (p == 0);
            e_en   = act;
            e_hs   = !(h < HS);
            e_vs   = !(v < VS);
            e_fs   = fs_now;
            if (exp_rd) begin
                e_data = mem[exp_idx];
                exp_idx++;
            end else if (act) begin
`ifdef FEEDER_UNDERFLOW_FILL_EN
                e_data = 16'h00FF;
`endif
            end
`ifdef FEEDER_UNDERFLOW_FILL_EN
            if (fs_now) e_uf = 1'b0;
            else if (act && empty) e_uf = 1'b1;
`endif
            p = (p + 1) % FT;
        end
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < FT && p != target; i++) tick(1'b1, 1'b0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        dut_idx = 0;
        exp_idx = 0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = (i < 100) ? 16'(i) : 16'($urandom);
        end
        reset_n    = 1'b0;
        fifo_empty = 1'b0;
        fifo_q     = 16'h0000;
        p = 0; e_en = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_data = 0; e_uf = 0;
        last_fs = -1; en_cnt = 0;
        @(posedge clk_9);
        #1;

        // Reset for 5 cycles, then two frames with the FIFO never empty
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 2 * FT; i++) tick(1'b1, 1'b0);

        // Three starved slots mid-line, then run past the next frame start
        run_to(pos(VS + VB + 1, HS + HB + 4));
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < FT; i++) tick(1'b1, 1'b0);

        // Random FIFO starvation over two frames
        for (int i = 0; i < 2 * FT; i++) tick(1'b1, ($urandom_range(0, 3) == 0));

        // One-cycle reset mid-line inside the active region
        run_to(pos(VS + VB + 2, HS + HB + 5));
        tick(1'b0, 1'b0);
        for (int i = 0; i < FT + 5; i++) tick(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
